// File: rtl/mcbsp_frame_rx.sv
// McBSP receive framer: synchronises clkr/fsr/miso into mcbsp_clk_in and rebuilds MSB-first words,
// counting words per burst and flagging framing and length errors.
module mcbsp_frame_rx #(
  parameter int WORD_LEN     = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic        mcbsp_clk_in,
  input  logic        mcbsp_rst_in,
  input  logic        cfg_en,
  input  logic [14:0] cfg_word_number,
  input  logic        mcbsp_rx_clk,
  input  logic        mcbsp_rx_fs,
  input  logic        mcbsp_rx_data,
  output logic [31:0] rx_data_out,
  output logic        rx_vaild_out,
  output logic [14:0] rx_word_cnt,
  output logic        rx_burst_done,
  output logic        rx_len_err,
  output logic        rx_fs_err,
  output logic [63:0] debug_signal
);

  localparam int TOW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, GAP = 2'd2} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, fs_sync_q, dat_sync_q;
  logic                   clk_dly_q;
  logic                   bclk_re, fs_s, dat_s;

  state_e              state_q, state_d;
  logic [5:0]          bit_q, bit_d;
  logic [14:0]         wcnt_q, wcnt_d, num_q, num_d;
  logic [TOW-1:0]      to_q, to_d, to_inc;
  logic [WORD_LEN-1:0] shreg_q, shreg_d, data_q, data_d;
  logic                cmpl_q, cmpl_d, last_q, last_d;
  logic                to_evt, lerr_evt, ferr_evt;
  logic                vaild_q, done_q, lerr_q, ferr_q;

  // fs/data come from the same stage as clk so the sampled bit lines up with its edge
  assign bclk_re = clk_sync_q[SYNC_STAGES-1] & ~clk_dly_q;
  assign fs_s    = fs_sync_q[SYNC_STAGES-1];
  assign dat_s   = dat_sync_q[SYNC_STAGES-1];

  always_ff @(posedge mcbsp_clk_in) begin
    if (mcbsp_rst_in) begin
      clk_sync_q <= '0;
      fs_sync_q  <= '0;
      dat_sync_q <= '0;
      clk_dly_q  <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], mcbsp_rx_clk};
      fs_sync_q  <= {fs_sync_q[SYNC_STAGES-2:0], mcbsp_rx_fs};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], mcbsp_rx_data};
      clk_dly_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign to_inc = (to_q == TOW'(IDLE_TIMEOUT)) ? to_q : to_q + TOW'(1);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    wcnt_d   = wcnt_q;
    num_d    = num_q;
    to_d     = to_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    cmpl_d   = 1'b0;
    last_d   = 1'b0;
    to_evt   = 1'b0;
    lerr_evt = 1'b0;
    ferr_evt = 1'b0;
    if (!cfg_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          to_d = '0;
          if (bclk_re && fs_s) begin
            state_d = DATA;
            bit_d   = '0;
            num_d   = cfg_word_number;
            wcnt_d  = '0;
          end
        end
        DATA, GAP: begin
          if (bclk_re) begin
            to_d = '0;
            if (fs_s) begin
              // a sync mid-word restarts the word; the partial bits are simply overwritten
              if (state_q == DATA && bit_q != '0) ferr_evt = 1'b1;
              state_d = DATA;
              bit_d   = '0;
            end else if (state_q == DATA) begin
              shreg_d = {shreg_q[WORD_LEN-2:0], dat_s};
              bit_d   = bit_q + 6'd1;
              if (bit_q == 6'(WORD_LEN - 1)) begin
                data_d = shreg_d;
                cmpl_d = 1'b1;
                bit_d  = '0;
                wcnt_d = (wcnt_q == 15'h7FFF) ? wcnt_q : wcnt_q + 15'd1;
                if (num_q != '0 && wcnt_d == num_q) begin
                  last_d  = 1'b1;
                  state_d = IDLE;
                end else begin
                  state_d = GAP;
                end
              end
            end
          end else begin
            to_d = to_inc;
            if (to_inc == TOW'(IDLE_TIMEOUT)) begin
              to_evt   = 1'b1;
              lerr_evt = (num_q != '0) && (wcnt_q < num_q);
              bit_d    = '0;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge mcbsp_clk_in) begin
    if (mcbsp_rst_in) begin
      state_q <= IDLE;
      bit_q   <= '0;
      wcnt_q  <= '0;
      num_q   <= '0;
      to_q    <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      cmpl_q  <= 1'b0;
      last_q  <= 1'b0;
      vaild_q <= 1'b0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      wcnt_q  <= wcnt_d;
      num_q   <= num_d;
      to_q    <= to_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      cmpl_q  <= cmpl_d;
      last_q  <= last_d;
      // completion strobes are delayed one cycle so vaild/done line up with the timeout path
      vaild_q <= cmpl_q;
      done_q  <= (last_q & cfg_en) | to_evt;
      lerr_q  <= lerr_evt;
      ferr_q  <= ferr_evt;
    end
  end

  assign rx_data_out   = 32'(data_q);
  assign rx_vaild_out  = vaild_q;
  assign rx_word_cnt   = wcnt_q;
  assign rx_burst_done = done_q;
  assign rx_len_err    = lerr_q;
  assign rx_fs_err     = ferr_q;
  assign debug_signal  = {state_q, bit_q, wcnt_q, clk_sync_q[SYNC_STAGES-1], fs_s, dat_s,
                          clk_dly_q, 16'(to_q), 21'd0};

endmodule

// File: tb/tb_mcbsp_frame_rx.sv
// Scoreboard bench for mcbsp_frame_rx: stimulus pushes expected words/burst ends, a monitor pops on pulses.
module tb_mcbsp_frame_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_en = 1'b1;
  logic [14:0] cfg_num = '0;
  logic        rx_clk = 1'b0, rx_fs = 1'b0, rx_dat = 1'b0;
  logic [31:0] rx_data_out;
  logic        rx_vaild_out, rx_burst_done, rx_len_err, rx_fs_err;
  logic [14:0] rx_word_cnt;
  logic [63:0] debug_signal;

  typedef struct {
    logic        lerr;
    logic [14:0] cnt;
    logic        with_v;
  } done_t;

  logic [31:0] exp_data[$];
  done_t       exp_done[$];
  int          checks = 0, failures = 0, fs_err_seen = 0;

  mcbsp_frame_rx dut (
    .mcbsp_clk_in(clk), .mcbsp_rst_in(rst), .cfg_en(cfg_en), .cfg_word_number(cfg_num),
    .mcbsp_rx_clk(rx_clk), .mcbsp_rx_fs(rx_fs), .mcbsp_rx_data(rx_dat),
    .rx_data_out(rx_data_out), .rx_vaild_out(rx_vaild_out), .rx_word_cnt(rx_word_cnt),
    .rx_burst_done(rx_burst_done), .rx_len_err(rx_len_err), .rx_fs_err(rx_fs_err),
    .debug_signal(debug_signal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=pulse expected=none", name);
  endtask

  // monitor: pops expectations whenever the DUT pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_vaild_out) begin
        if (exp_data.size() == 0) unexpected("vaild_unexpected");
        else chk("vaild_data", rx_data_out, exp_data.pop_front());
      end
      if (rx_burst_done) begin
        if (exp_done.size() == 0) unexpected("done_unexpected");
        else begin
          done_t d;
          d = exp_done.pop_front();
          chk("done_cnt", rx_word_cnt, d.cnt);
          chk("done_len_err", rx_len_err, d.lerr);
          chk("done_with_vaild", rx_vaild_out, d.with_v);
        end
      end else if (rx_len_err) unexpected("len_err_without_done");
      if (rx_fs_err) fs_err_seen++;
    end
  end

  task automatic send_bit(input logic f, input logic d);
    @(negedge clk);
    rx_clk = 1'b0;
    rx_fs  = f;
    rx_dat = d;
    repeat (4) @(negedge clk);
    rx_clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_data.push_back(w);
    send_bit(1'b1, 1'b0);
    for (int i = 31; i >= 0; i--) send_bit(1'b0, w[i]);
  endtask

  task automatic push_done(input logic lerr, input logic [14:0] cnt, input logic with_v);
    done_t d;
    d.lerr = lerr; d.cnt = cnt; d.with_v = with_v;
    exp_done.push_back(d);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_data"}, rx_data_out, 0);
    chk({tag, "_vaild"}, rx_vaild_out, 0);
    chk({tag, "_cnt"}, rx_word_cnt, 0);
    chk({tag, "_flags"}, {rx_burst_done, rx_len_err, rx_fs_err}, 0);
    chk({tag, "_debug"}, debug_signal, 0);
  endtask

  initial begin
    logic [31:0] w;
    repeat (3) @(negedge clk);
    check_reset_state("rst0");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: four-word burst; cfg change after the first word must be ignored
    cfg_num = 15'd4;
    send_word(32'hA5A50001);
    cfg_num = 15'd1;
    send_word(32'hA5A50002);
    send_word(32'hA5A50003);
    push_done(1'b0, 15'd4, 1'b1);
    send_word(32'hA5A50004);
    repeat (20) @(negedge clk);

    // 2: sync after 10 bits aborts the word, then a full word follows
    cfg_num = 15'd1;
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b0, i[0]);
    push_done(1'b0, 15'd1, 1'b1);
    send_word(32'h12345678);
    repeat (20) @(negedge clk);

    // 3: short burst closed by timeout raises len_err
    cfg_num = 15'd5;
    send_word(32'h0BADF00D);
    send_word(32'hCAFE0002);
    send_word(32'h00000003);
    push_done(1'b1, 15'd3, 1'b0);
    repeat (4300) @(negedge clk);

    // 4: unlimited burst ends only on timeout, no len_err
    cfg_num = 15'd0;
    for (int i = 0; i < 6; i++) begin
      w = 32'h11111111 * i;
      send_word(w);
    end
    push_done(1'b0, 15'd6, 1'b0);
    repeat (4300) @(negedge clk);

    // 5: reset in the middle of a word
    cfg_num = 15'd2;
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 17; i++) send_bit(1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_word(32'h80000000);
    push_done(1'b0, 15'd2, 1'b1);
    send_word(32'h00000001);
    repeat (20) @(negedge clk);

    // 6: two bursts back to back, sync right after the last bit
    cfg_num = 15'd2;
    send_word(32'hDEADBEEF);
    push_done(1'b0, 15'd2, 1'b1);
    send_word(32'hFFFFFFFF);
    send_word(32'h00000000);
    push_done(1'b0, 15'd2, 1'b1);
    send_word(32'h5A5A5A5A);
    repeat (60) @(negedge clk);

    chk("exp_data_left", exp_data.size(), 0);
    chk("exp_done_left", exp_done.size(), 0);
    chk("fs_err_count", fs_err_seen, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
